ysyx_24110015_lsu: RTL and testbench
====================================

# ysyx_24110015_lsu

Multi-cycle load/store unit sitting directly downstream of the EXU. It takes one memory request per transaction (address, store data, MemOp, MemRead/MemWrite) over a valid/ready handshake. It drives a single-outstanding memory bus with byte-lane write masks, and returns aligned, sign/zero-extended load data (or a store-complete token) to write-back. Misaligned, illegal-op and timed-out accesses complete with an error flag instead of hanging the core.

## Interface
- TIMEOUT, 255: maximum cycles spent waiting for `mem_rsp_valid` before the access is aborted with error; legal range 1..65535.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  EXU presents a memory request.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_ren  in  1  load (MemRead).
- req_wen  in  1  store (MemWrite).
- req_op  in  3  MemOp: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  32  word address (`{req_addr[31:2],2'b00}`).
- mem_req_wdata  out  32  lane-shifted store data.
- mem_req_wmask  out  4  byte-enable; 0000 on reads.
- mem_rsp_valid  in  1  bus response (read data or write ack).
- mem_rsp_ready  out  1  high only in WAIT.
- mem_rsp_rdata  in  32  read word.
- mem_rsp_err  in  1  bus error.
- rsp_valid  out  1  result available to write-back.
- rsp_ready  in  1  write-back consumes result.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal op, bus error or timeout.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE; all outputs 0 except `req_ready`=1.
- IDLE: on `req_valid`, latch all request fields. Then check the request:
  - misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0), illegal op, or `req_ren`==`req_wen` → DONE with err=1 and no bus access.
  - otherwise → REQ.
- REQ: `mem_req_valid`=1 and outputs stable until `mem_req_ready`; then → WAIT, timeout counter cleared.
- WAIT: on `mem_rsp_valid` → DONE.
  - err = `mem_rsp_err`.
  - for loads, capture the extended data.
  - counter increments each WAIT cycle without response; reaching TIMEOUT → DONE with err=1. A late response is then ignored because `mem_rsp_ready`=0.
- DONE: `rsp_valid`=1 and outputs held until `rsp_ready`; then → IDLE. `rsp_err` with `rsp_rdata`=0 on any error.
- Store lanes, sh = addr[1:0]:
  - B: wdata = {4{wdata[7:0]}}, mask = 0001<<sh.
  - H: wdata = {2{wdata[15:0]}}, mask = 0011<<sh.
  - W: wdata unchanged, mask = 1111.
- Load extraction: word >> (8·sh), then B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged.

## Timing
- Accept edge T (IDLE, req_valid). `mem_req_valid` high from T+1. Minimum latency to `rsp_valid` is 3 cycles (T+3), with mem_req_ready at T+1 and mem_rsp_valid at T+2.
- Error-at-decode path: `rsp_valid` at T+1, no bus activity.
- One transaction outstanding; `req_ready`=0 from T+1 until return to IDLE. A new request is accepted the cycle after the DONE handshake.
- `mem_rsp_valid` outside WAIT is ignored. A response is never taken in the same cycle as the REQ handshake.
- Timeout: with no response, DONE is entered after exactly TIMEOUT WAIT cycles.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs cleared, any bus response afterward ignored.

## Test plan
- LB at 0x8000_0003, mem returns 0x80FF_0000 → wmask 0000, rsp_rdata 0xFFFF_FF80, err 0, rsp_valid at T+3 with zero-wait bus.
- SH data 0x1234_ABCD at 0x8000_0002 → mem_req_addr 0x8000_0000, wdata 0xABCD_ABCD, wmask 1100; ack → rsp_valid, rdata 0.
- LW at 0x8000_0006 → rsp_valid T+1, err 1, mem_req_valid never asserted; same for op 011 and for ren=wen=1.
- LHU, mem_req_ready delayed 4 cycles and rsp delayed 3 → request fields stable throughout; rdata zero-extended; rsp_ready held low 2 cycles keeps outputs stable.
- TIMEOUT=8, no response → err after exactly 8 WAIT cycles; a response injected later is ignored; next request completes normally.
- Reset pulsed during WAIT → IDLE, req_ready=1, rsp_valid=0; a following LW at 0x8000_0000 succeeds.

Source files
------------

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: one outstanding bus access per request, with
// byte-lane stores, extended loads and error/timeout completion.
module ysyx_24110015_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_ren,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        wen_q, wen_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic [1:0]  sh_in;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;
    logic        op_ok;
    logic        misal;
    logic [31:0] rsp_word;
    logic [31:0] ext_data;

    assign sh_in = req_addr[1:0];

    always_comb begin
        lane_wdata = req_wdata;
        lane_mask  = 4'b1111;
        op_ok      = 1'b1;
        misal      = 1'b0;
        unique case (req_op)
            3'b000, 3'b100: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_mask  = 4'b0001 << sh_in;
            end
            3'b001, 3'b101: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_mask  = 4'b0011 << sh_in;
                misal      = sh_in[0];
            end
            3'b010: misal = |sh_in;
            default: op_ok = 1'b0;
        endcase
    end

    assign rsp_word = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext_data = rsp_word;
        unique case (op_q)
            3'b000: ext_data = {{24{rsp_word[7]}}, rsp_word[7:0]};
            3'b100: ext_data = {24'd0, rsp_word[7:0]};
            3'b001: ext_data = {{16{rsp_word[15]}}, rsp_word[15:0]};
            3'b101: ext_data = {16'd0, rsp_word[15:0]};
            default: ext_data = rsp_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = lane_wdata;
                    wmask_d = req_wen ? lane_mask : 4'b0000;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!op_ok || misal || (req_ren == req_wen)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    err_d   = mem_rsp_err;
                    rdata_d = (wen_q || mem_rsp_err) ? '0 : ext_data;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus fields are only driven while the request is on the bus.
    assign req_ready     = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_wen   = mem_req_valid & wen_q;
    assign mem_req_addr  = mem_req_valid ? {addr_q[31:2], 2'b00} : '0;
    assign mem_req_wdata = mem_req_valid ? wdata_q : '0;
    assign mem_req_wmask = mem_req_valid ? wmask_q : '0;
    assign mem_rsp_ready = (state_q == WAIT);
    assign rsp_valid     = (state_q == DONE);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Randomized and directed bench for the LSU with an arithmetic
// reference model and a simple bus/write-back responder.
module tb_ysyx_24110015_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_ren, req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int errs = 0;
    int checks = 0;

    int          o_lat, o_wait;
    logic [31:0] o_rdata, o_maddr, o_mwdata;
    logic [3:0]  o_mask;
    logic        o_err, o_saw, o_mwen, o_stable, o_held;

    always #5 clk = ~clk;

    ysyx_24110015_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ren(req_ren), .req_wen(req_wen), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Reference model derived from the access size and byte offset.
    task automatic model(
        input  logic ren, input logic wen, input logic [2:0] op,
        input  logic [31:0] addr, input logic [31:0] wdata,
        input  logic [31:0] mrdata, input logic merr,
        output logic dec, output logic err, output logic [31:0] rdata,
        output logic [31:0] mwdata, output logic [3:0] mask);
        int size, sh;
        longint v;
        logic legal;
        legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
                (op == 3'd4) || (op == 3'd5);
        size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        sh = int'(addr[1:0]);
        dec = !legal || (ren == wen) || ((sh % size) != 0);
        for (int i = 0; i < 4; i++) begin
            mwdata[8*i +: 8] = wdata[8*(i % size) +: 8];
            mask[i] = wen && (i >= sh) && (i < sh + size);
        end
        v = (longint'(mrdata) >> (8 * sh)) &
            ((longint'(1) << (8 * size)) - 1);
        if (!op[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        err = dec || merr;
        rdata = (err || !ren) ? 32'd0 : 32'(v);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        req_valid = 0; req_ren = 0; req_wen = 0; req_op = '0;
        req_addr = '0; req_wdata = '0;
        mem_req_ready = 0; mem_rsp_valid = 0;
        mem_rsp_rdata = '0; mem_rsp_err = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issue one request at the current negedge and play bus + consumer.
    task automatic run_txn(
        input logic ren, input logic wen, input logic [2:0] op,
        input logic [31:0] addr, input logic [31:0] wdata,
        input int rdy, input int rsp,
        input logic [31:0] mrdata, input logic merr,
        input int hold, input logic late);
        int rc, wc;
        logic done;
        req_valid = 1; req_ren = ren; req_wen = wen; req_op = op;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 0;
        o_saw = 0; o_stable = 1; o_held = 1; o_wait = 0; o_lat = 0;
        o_rdata = '0; o_err = 0; o_maddr = '0; o_mwdata = '0;
        o_mask = '0; o_mwen = 0;
        rc = 0; wc = 0; done = 0;
        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                o_lat = c; o_rdata = rsp_rdata; o_err = rsp_err;
                done = 1; mem_req_ready = 0; mem_rsp_valid = 0;
            end else begin
                if (mem_req_valid) begin
                    if (!o_saw) begin
                        o_saw = 1; o_maddr = mem_req_addr;
                        o_mwdata = mem_req_wdata; o_mask = mem_req_wmask;
                        o_mwen = mem_req_wen;
                    end else if (mem_req_addr !== o_maddr ||
                                 mem_req_wdata !== o_mwdata ||
                                 mem_req_wmask !== o_mask ||
                                 mem_req_wen !== o_mwen) begin
                        o_stable = 0;
                    end
                    mem_req_ready = (rc >= rdy);
                    rc++;
                end else begin
                    mem_req_ready = 0;
                end
                if (mem_rsp_ready) begin
                    o_wait++;
                    mem_rsp_valid = (rsp >= 0) && (wc >= rsp);
                    mem_rsp_rdata = mem_rsp_valid ? mrdata : $urandom;
                    mem_rsp_err = merr;
                    wc++;
                end else begin
                    mem_rsp_valid = 0;
                end
            end
        end
        checks++;
        if (!done) begin
            errs++;
            $display("FAIL txn_timeout got=no_rsp_valid exp=rsp_valid");
        end else begin
            repeat (hold) begin
                if (late) begin
                    mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF;
                    mem_rsp_err = 0;
                end
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata ||
                    rsp_err !== o_err)
                    o_held = 0;
            end
            mem_rsp_valid = 0;
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({req_ready, mem_req_valid, mem_rsp_ready, rsp_valid,
             rsp_err, mem_req_wen} !== 6'b100000) begin
            errs++;
            $display("FAIL reset_ctl got=%b exp=100000",
                     {req_ready, mem_req_valid, mem_rsp_ready,
                      rsp_valid, rsp_err, mem_req_wen});
        end
        checks++;
        if (rsp_rdata !== 0 || mem_req_addr !== 0 ||
            mem_req_wdata !== 0 || mem_req_wmask !== 0) begin
            errs++;
            $display("FAIL reset_data got=%h/%h exp=0/0",
                     rsp_rdata, mem_req_addr);
        end
    endtask

    task automatic test_lb();
        run_txn(1, 0, 3'b000, 32'h8000_0003, $urandom, 0, 0,
                32'h80FF_0000, 0, 0, 0);
        checks++;
        if (o_lat !== 3) begin
            errs++; $display("FAIL lb_latency got=%0d exp=3", o_lat);
        end
        checks++;
        if (o_rdata !== 32'hFFFF_FF80 || o_err !== 0) begin
            errs++;
            $display("FAIL lb_rdata got=%h/%b exp=ffffff80/0",
                     o_rdata, o_err);
        end
        checks++;
        if (o_mask !== 4'b0000 || o_mwen !== 0 ||
            o_maddr !== 32'h8000_0000) begin
            errs++;
            $display("FAIL lb_bus got=%b/%b/%h exp=0000/0/80000000",
                     o_mask, o_mwen, o_maddr);
        end
        checks++;
        if (req_ready !== 1) begin
            errs++; $display("FAIL lb_idle got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_sh();
        run_txn(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 0, 0,
                $urandom, 0, 0, 0);
        checks++;
        if (o_maddr !== 32'h8000_0000 || o_mwdata !== 32'hABCD_ABCD) begin
            errs++;
            $display("FAIL sh_bus got=%h/%h exp=80000000/abcdabcd",
                     o_maddr, o_mwdata);
        end
        checks++;
        if (o_mask !== 4'b1100 || o_mwen !== 1) begin
            errs++;
            $display("FAIL sh_mask got=%b/%b exp=1100/1", o_mask, o_mwen);
        end
        checks++;
        if (o_rdata !== 0 || o_err !== 0 || o_lat !== 3) begin
            errs++;
            $display("FAIL sh_rsp got=%h/%b/%0d exp=0/0/3",
                     o_rdata, o_err, o_lat);
        end
    endtask

    task automatic test_decode_err();
        logic [31:0] ad [3];
        logic [2:0]  op [3];
        logic        wn [3];
        ad = '{32'h8000_0006, 32'h8000_0004, 32'h8000_0008};
        op = '{3'b010, 3'b011, 3'b010};
        wn = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_txn(1, wn[i], op[i], ad[i], $urandom, 0, 0,
                    $urandom, 0, 0, 0);
            checks++;
            if (o_lat !== 1 || o_err !== 1 || o_saw !== 0 ||
                o_rdata !== 0) begin
                errs++;
                $display("FAIL dec_err%0d got=%0d/%b/%b/%h exp=1/1/0/0",
                         i, o_lat, o_err, o_saw, o_rdata);
            end
        end
    endtask

    task automatic test_lhu_stall();
        run_txn(1, 0, 3'b101, 32'h8000_0002, $urandom, 4, 3,
                32'hF00D_1234, 0, 2, 0);
        checks++;
        if (o_lat !== 10) begin
            errs++; $display("FAIL lhu_latency got=%0d exp=10", o_lat);
        end
        checks++;
        if (o_stable !== 1 || o_held !== 1) begin
            errs++;
            $display("FAIL lhu_stable got=%b/%b exp=1/1",
                     o_stable, o_held);
        end
        checks++;
        if (o_rdata !== 32'h0000_F00D || o_err !== 0) begin
            errs++;
            $display("FAIL lhu_rdata got=%h/%b exp=0000f00d/0",
                     o_rdata, o_err);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        run_txn(1, 0, 3'b010, 32'h8000_0010, 0, 0, -1, 0, 0, 2, 1);
        checks++;
        if (o_wait !== TO || o_lat !== TO + 2) begin
            errs++;
            $display("FAIL to_cycles got=%0d/%0d exp=%0d/%0d",
                     o_wait, o_lat, TO, TO + 2);
        end
        checks++;
        if (o_err !== 1 || o_rdata !== 0 || o_held !== 1) begin
            errs++;
            $display("FAIL to_rsp got=%b/%h/%b exp=1/0/1",
                     o_err, o_rdata, o_held);
        end
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rsp_valid = 0;
        checks++;
        if (rsp_valid !== 0 || req_ready !== 1 || mem_rsp_ready !== 0) begin
            errs++;
            $display("FAIL to_stray got=%b/%b/%b exp=0/1/0",
                     rsp_valid, req_ready, mem_rsp_ready);
        end
        d = $urandom;
        run_txn(1, 0, 3'b010, 32'h8000_0020, 0, 1, 1, d, 0, 0, 0);
        checks++;
        if (o_rdata !== d || o_err !== 0 || o_lat !== 5) begin
            errs++;
            $display("FAIL to_next got=%h/%b/%0d exp=%h/0/5",
                     o_rdata, o_err, o_lat, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        req_valid = 1; req_ren = 1; req_wen = 0; req_op = 3'b010;
        req_addr = 32'h8000_0040;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        checks++;
        if (mem_rsp_ready !== 1) begin
            errs++;
            $display("FAIL rm_wait got=%b exp=1", mem_rsp_ready);
        end
        rst = 0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, mem_req_valid, mem_rsp_ready}
            !== 4'b1000) begin
            errs++;
            $display("FAIL rm_idle got=%b exp=1000",
                     {req_ready, rsp_valid, mem_req_valid, mem_rsp_ready});
        end
        @(negedge clk);
        rst = 1;
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rsp_valid = 0;
        checks++;
        if (rsp_valid !== 0 || req_ready !== 1) begin
            errs++;
            $display("FAIL rm_ignore got=%b/%b exp=0/1",
                     rsp_valid, req_ready);
        end
        d = $urandom;
        run_txn(1, 0, 3'b010, 32'h8000_0000, 0, 0, 0, d, 0, 0, 0);
        checks++;
        if (o_rdata !== d || o_err !== 0 || o_lat !== 3) begin
            errs++;
            $display("FAIL rm_lw got=%h/%b/%0d exp=%h/0/3",
                     o_rdata, o_err, o_lat, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  lops [5];
        logic [2:0]  op;
        logic        ren, wen, merr, dec, e_err;
        logic [31:0] addr, wd, md, e_rd, e_wd;
        logic [3:0]  e_mk;
        int          r, rdy, rsp, lat;
        lops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 2);
                op = (r == 0) ? 3'd3 : (r == 1) ? 3'd6 : 3'd7;
            end else begin
                op = lops[$urandom_range(0, 4)];
            end
            r = $urandom_range(0, 9);
            ren = (r <= 4) || (r == 9 && n[0]);
            wen = (r >= 5 && r <= 8) || (r == 9 && n[0]);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom; md = $urandom;
            merr = ($urandom_range(0, 9) == 0);
            rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
            model(ren, wen, op, addr, wd, md, merr,
                  dec, e_err, e_rd, e_wd, e_mk);
            run_txn(ren, wen, op, addr, wd, rdy, rsp, md, merr,
                    $urandom_range(0, 2), 0);
            lat = dec ? 1 : 3 + rdy + rsp;
            checks++;
            if (o_lat !== lat || o_saw !== !dec) begin
                errs++;
                $display("FAIL rnd%0d_lat got=%0d/%b exp=%0d/%b",
                         n, o_lat, o_saw, lat, !dec);
            end
            checks++;
            if (o_rdata !== e_rd || o_err !== e_err || o_held !== 1) begin
                errs++;
                $display("FAIL rnd%0d_rsp got=%h/%b exp=%h/%b",
                         n, o_rdata, o_err, e_rd, e_err);
            end
            if (!dec) begin
                checks++;
                if (o_maddr !== {addr[31:2], 2'b00} || o_mask !== e_mk ||
                    o_mwen !== wen || o_stable !== 1 ||
                    (wen && o_mwdata !== e_wd)) begin
                    errs++;
                    $display("FAIL rnd%0d_bus got=%h/%h/%b exp=%h/%h/%b",
                             n, o_maddr, o_mwdata, o_mask,
                             {addr[31:2], 2'b00}, e_wd, e_mk);
                end
            end
            checks++;
            if (req_ready !== 1) begin
                errs++;
                $display("FAIL rnd%0d_idle got=%b exp=1", n, req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_decode_err();
        test_lhu_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
